// File: rtl/partial_sum_acc.sv
// ---------------------------------------------------------------------------
// partial_sum_acc
//
// Accumulates partial sums from N_MACRO compute macros into N_CH signed
// per-channel results.
//
// Each raw macro element is decoded as {raw[MSB], ~raw[MSB-1:0]} and
// sign-extended. The decoded elements of one beat are summed per channel.
// Those beat sums are then accumulated over a group of pass_num beats.
// One cycle after the completing beat, the final sums appear on the
// registered data_out, and data_e_out pulses for one cycle.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   mode        1 = calculate, 0 = idle/configure (aborts an open group)
//   data_e      input beat valid
//   pass_num    beats per group, sampled on the first beat (0 acts as 1)
//   acc_clr     synchronous abort/clear of the open group (beats data_e)
//   data_in     raw macro outputs, element (m,k) at [(m*N_CH+k)*IN_DW +: IN_DW]
//   data_out    channel k sum at [k*OUT_DW +: OUT_DW], signed, registered
//   data_e_out  one-cycle result-valid pulse
//   busy        high while a group is open
//   sat_flag    overflow seen in any channel during the last completed group
//
// Configuration macro
//   PSUM_SAT_EN  defined: each accumulate step saturates to the OUT_DW range.
//                undefined (default): accumulation wraps modulo 2^OUT_DW.
//                In both cases, overflow is reported on sat_flag.
// ---------------------------------------------------------------------------
module partial_sum_acc #(
    parameter int N_MACRO = 8,
    parameter int N_CH    = 64,
    parameter int IN_DW   = 4,
    parameter int OUT_DW  = 16,
    parameter int PASS_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              mode,
    input  logic                              data_e,
    input  logic [PASS_W-1:0]                 pass_num,
    input  logic                              acc_clr,
    input  logic [N_MACRO*N_CH*IN_DW-1:0]     data_in,
    output logic signed [N_CH*OUT_DW-1:0]     data_out,
    output logic                              data_e_out,
    output logic                              busy,
    output logic                              sat_flag
);

    // Beat-sum width and the one-bit-wider width of an accumulate step.
    localparam int BW = OUT_DW + $clog2(N_MACRO);
    localparam int EW = BW + 1;

    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1'b1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // Macro output code: the magnitude bits are inverted, and the sign bit is kept.
    function automatic logic signed [IN_DW-1:0] decode_elem(input logic [IN_DW-1:0] raw);
        decode_elem = {raw[IN_DW-1], ~raw[IN_DW-2:0]};
    endfunction

    // The value fits OUT_DW when all bits from the OUT_DW sign bit upward agree.
    function automatic logic fits_out(input logic signed [EW-1:0] v);
        logic [EW-OUT_DW:0] top_v;
        top_v    = v[EW-1:OUT_DW-1];
        fits_out = (&top_v) | (~|top_v);
    endfunction

    // Clamp an out-of-range step to the nearest OUT_DW signed extreme.
    function automatic logic signed [OUT_DW-1:0] sat_value(input logic signed [EW-1:0] v);
        sat_value = v[EW-1] ? {1'b1, {(OUT_DW-1){1'b0}}} : {1'b0, {(OUT_DW-1){1'b1}}};
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [PASS_W-1:0]         cnt_r;
    logic [PASS_W-1:0]         pass_lat_r;
    logic [PASS_W-1:0]         cnt_inc_s;
    logic [PASS_W-1:0]         eff_pass_s;
    logic                      accept_s;
    logic                      load_s;
    logic                      add_s;
    logic                      abort_s;
    logic                      done_s;
    logic                      grp_ovf_r;
    logic [N_CH-1:0]           ovf_s;
    logic signed [OUT_DW-1:0]  acc_r     [N_CH];
    logic signed [OUT_DW-1:0]  acc_nxt_s [N_CH];
    logic signed [BW-1:0]      beat_sum_s[N_CH];

    // Decode the beat qualifier, the effective group length and the incremented count.
    always_comb begin
        accept_s   = mode & data_e & ~acc_clr;
        eff_pass_s = (pass_num == {PASS_W{1'b0}}) ? PASS_ONE : pass_num;
        cnt_inc_s  = cnt_r + PASS_ONE;
    end

    // Hold the FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Compute the next FSM state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (eff_pass_s != PASS_ONE)) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (!mode || acc_clr) begin
                    state_nxt_s = ST_IDLE;
                end else if (data_e && (cnt_inc_s == pass_lat_r)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Generate the datapath strobes for the current state.
    always_comb begin
        load_s  = 1'b0;
        add_s   = 1'b0;
        abort_s = 1'b0;
        done_s  = 1'b0;
        busy    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = accept_s;
                done_s = accept_s & (eff_pass_s == PASS_ONE);
            end
            ST_ACC: begin
                busy    = 1'b1;
                abort_s = ~mode | acc_clr;
                add_s   = ~abort_s & data_e;
                done_s  = add_s & (cnt_inc_s == pass_lat_r);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Compute the per-channel beat sum and the next accumulator value with overflow detection.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            logic signed [OUT_DW-1:0] base_v;
            logic signed [EW-1:0]     step_v;
            beat_sum_s[k] = {BW{1'b0}};
            for (int m = 0; m < N_MACRO; m++) begin
                beat_sum_s[k] = beat_sum_s[k]
                              + BW'(decode_elem(data_in[(m*N_CH+k)*IN_DW +: IN_DW]));
            end
            // The first beat of a group loads the accumulator rather than adding to it.
            base_v   = load_s ? {OUT_DW{1'b0}} : acc_r[k];
            step_v   = EW'(base_v) + EW'(beat_sum_s[k]);
            ovf_s[k] = ~fits_out(step_v);
`ifdef PSUM_SAT_EN
            acc_nxt_s[k] = ovf_s[k] ? sat_value(step_v) : step_v[OUT_DW-1:0];
`else
            acc_nxt_s[k] = step_v[OUT_DW-1:0];
`endif
        end
    end

    // Update the accumulators, the pass counter, the latched group length and the group overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {PASS_W{1'b0}};
            pass_lat_r <= {PASS_W{1'b0}};
            grp_ovf_r  <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                acc_r[k] <= {OUT_DW{1'b0}};
            end
        end else if (done_s || abort_s) begin
            // The result is captured in data_out, so the working state is cleared for the next group.
            cnt_r     <= {PASS_W{1'b0}};
            grp_ovf_r <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                acc_r[k] <= {OUT_DW{1'b0}};
            end
        end else if (load_s) begin
            cnt_r      <= PASS_ONE;
            pass_lat_r <= eff_pass_s;
            grp_ovf_r  <= |ovf_s;
            acc_r      <= acc_nxt_s;
        end else if (add_s) begin
            cnt_r     <= cnt_inc_s;
            grp_ovf_r <= grp_ovf_r | (|ovf_s);
            acc_r     <= acc_nxt_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Register the results, the valid pulse and the overflow flag on group completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= {(N_CH*OUT_DW){1'b0}};
            data_e_out <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            data_e_out <= done_s;
            if (done_s) begin
                sat_flag <= grp_ovf_r | (|ovf_s);
                for (int k = 0; k < N_CH; k++) begin
                    data_out[k*OUT_DW +: OUT_DW] <= acc_nxt_s[k];
                end
            end else begin
                sat_flag <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_partial_sum_acc.sv
// ---------------------------------------------------------------------------
// tb_partial_sum_acc
//
// Directed self-checking bench. Instance dut uses the default parameters.
// Instance dut8 uses OUT_DW=8 and N_CH=4, so the overflow and saturation
// behaviour can be observed. Both instances share the control inputs.
// Inputs are driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_partial_sum_acc;

    localparam int NM  = 8;
    localparam int NC  = 64;
    localparam int NC2 = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mode;
    logic              data_e;
    logic [3:0]        pass_num;
    logic              acc_clr;
    logic [NM*NC*4-1:0]  data_in;
    logic [NM*NC2*4-1:0] data_in2;
    logic [NC*16-1:0]  data_out;
    logic [NC2*8-1:0]  data_out2;
    logic              data_e_out, data_e_out2;
    logic              busy, busy2;
    logic              sat_flag, sat_flag2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    partial_sum_acc dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .data_e(data_e),
        .pass_num(pass_num), .acc_clr(acc_clr), .data_in(data_in),
        .data_out(data_out), .data_e_out(data_e_out), .busy(busy),
        .sat_flag(sat_flag)
    );

    partial_sum_acc #(.N_MACRO(NM), .N_CH(NC2), .IN_DW(4), .OUT_DW(8), .PASS_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .data_e(data_e),
        .pass_num(pass_num), .acc_clr(acc_clr), .data_in(data_in2),
        .data_out(data_out2), .data_e_out(data_e_out2), .busy(busy2),
        .sat_flag(sat_flag2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_all(input logic [3:0] nib);
        data_in  = {(NM*NC){nib}};
        data_in2 = {(NM*NC2){nib}};
    endtask

    function automatic logic [1023:0] rep16(input logic [15:0] v);
        logic [1023:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) r[k*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [1023:0] rep8(input logic [7:0] v);
        logic [1023:0] r;
        r = '0;
        for (int k = 0; k < NC2; k++) r[k*8 +: 8] = v;
        return r;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [1023:0] obs,
                           input logic [1023:0] exp, input int dw);
        int first;
        first = 0;
        checks++;
        assert (obs === exp) else begin
            errors++;
            for (int i = 1023; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
            $error("FAIL %s channel=%0d observed=%0h expected=%0h", tag, first / dw,
                   (obs >> ((first / dw) * dw)) & ((1024'(1) << dw) - 1),
                   (exp >> ((first / dw) * dw)) & ((1024'(1) << dw) - 1));
        end
    endtask

    initial begin
        logic [1023:0] exp_v;
        logic [1023:0] exp_v2;
        rst_n = 1'b0; mode = 1'b0; data_e = 1'b0; pass_num = 4'd0; acc_clr = 1'b0;
        set_all(4'b0000);
        tick();
        // Reset state.
        chk_vec("rst_data_out", {{(1024-NC*16){1'b0}}, data_out}, '0, 16);
        chk("rst_e_out", data_e_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sat", sat_flag, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single-beat group: 7 x 8 = 56.
        mode = 1'b1; pass_num = 4'd1; data_e = 1'b1;
        tick();
        chk_vec("p1_sum56", data_out, rep16(16'd56), 16);
        chk("p1_e_out", data_e_out, 1'b1);
        chk("p1_busy", busy, 1'b0);
        data_e = 1'b0;
        tick();
        chk("p1_pulse_end", data_e_out, 1'b0);
        chk_vec("p1_hold", data_out, rep16(16'd56), 16);

        // Three beats of -64 with gaps; a pass_num change mid-group is ignored.
        pass_num = 4'd3; set_all(4'b1111); data_e = 1'b1;
        tick();
        chk("p3_busy1", busy, 1'b1);
        chk("p3_no_pulse1", data_e_out, 1'b0);
        chk_vec("p3_no_partial", data_out, rep16(16'd56), 16);
        data_e = 1'b0; pass_num = 4'd5;
        tick();
        chk("p3_busy_gap", busy, 1'b1);
        data_e = 1'b1;
        tick();
        chk("p3_busy2", busy, 1'b1);
        chk("p3_no_pulse2", data_e_out, 1'b0);
        data_e = 1'b0;
        tick();
        data_e = 1'b1;
        tick();
        chk_vec("p3_sum_m192", data_out, rep16(-16'sd192), 16);
        chk("p3_e_out", data_e_out, 1'b1);
        chk("p3_busy_done", busy, 1'b0);
        data_e = 1'b0;
        tick();
        chk("p3_pulse_end", data_e_out, 1'b0);

        // acc_clr abort, with priority over data_e, then a clean two-beat group.
        pass_num = 4'd2; set_all(4'b0000); data_e = 1'b1;
        tick();
        chk("clr_busy", busy, 1'b1);
        acc_clr = 1'b1;
        tick();
        chk("clr_idle", busy, 1'b0);
        chk("clr_no_pulse", data_e_out, 1'b0);
        acc_clr = 1'b0; data_e = 1'b0;
        tick();
        chk("clr_no_late_pulse", data_e_out, 1'b0);
        chk_vec("clr_out_held", data_out, rep16(-16'sd192), 16);
        set_all(4'b1111); data_e = 1'b1;
        tick();
        chk("clr_g2_busy", busy, 1'b1);
        tick();
        chk_vec("clr_g2_sum", data_out, rep16(-16'sd128), 16);
        chk("clr_g2_e_out", data_e_out, 1'b1);
        data_e = 1'b0;

        // mode=0 abort, then a two-beat group of 56s.
        set_all(4'b0000); data_e = 1'b1;
        tick();
        mode = 1'b0;
        tick();
        chk("mode_abort_idle", busy, 1'b0);
        chk("mode_abort_no_pulse", data_e_out, 1'b0);
        mode = 1'b1;
        tick();
        tick();
        chk_vec("mode_g2_sum112", data_out, rep16(16'd112), 16);
        chk("mode_g2_e_out", data_e_out, 1'b1);
        data_e = 1'b0;
        tick();

        // Back-to-back single-beat groups.
        pass_num = 4'd1; set_all(4'b0000); data_e = 1'b1;
        tick();
        chk_vec("b2b_first", data_out, rep16(16'd56), 16);
        chk("b2b_e1", data_e_out, 1'b1);
        set_all(4'b1111);
        tick();
        chk_vec("b2b_second", data_out, rep16(-16'sd64), 16);
        chk("b2b_e2", data_e_out, 1'b1);
        data_e = 1'b0;
        tick();
        chk("b2b_e_end", data_e_out, 1'b0);

        // pass_num 0 acts as 1; channel layout: odd channels -1 x 8, even channels 0.
        pass_num = 4'd0;
        for (int m = 0; m < NM; m++) begin
            for (int k = 0; k < NC; k++)
                data_in[(m*NC+k)*4 +: 4] = (k % 2 == 1) ? 4'b1000 : 4'b0111;
            for (int k = 0; k < NC2; k++)
                data_in2[(m*NC2+k)*4 +: 4] = (k % 2 == 1) ? 4'b1000 : 4'b0111;
        end
        exp_v = '0;
        exp_v2 = '0;
        for (int k = 0; k < NC; k++) exp_v[k*16 +: 16] = (k % 2 == 1) ? 16'hFFF8 : 16'h0000;
        for (int k = 0; k < NC2; k++) exp_v2[k*8 +: 8] = (k % 2 == 1) ? 8'hF8 : 8'h00;
        data_e = 1'b1;
        tick();
        chk_vec("pn0_layout", data_out, exp_v, 16);
        chk_vec("pn0_layout8", {{(1024-NC2*8){1'b0}}, data_out2}, exp_v2, 8);
        chk("pn0_e_out", data_e_out, 1'b1);
        data_e = 1'b0;
        tick();

        // Overflow: three beats of 56. The 8-bit instance overflows; the 16-bit one does not.
        pass_num = 4'd3; set_all(4'b0000); data_e = 1'b1;
        tick();
        tick();
        tick();
        chk_vec("ovf16_sum168", data_out, rep16(16'd168), 16);
        chk("ovf16_sat", sat_flag, 1'b0);
`ifdef PSUM_SAT_EN
        chk_vec("ovf8_sum", {{(1024-NC2*8){1'b0}}, data_out2}, rep8(8'd127), 8);
`else
        chk_vec("ovf8_sum", {{(1024-NC2*8){1'b0}}, data_out2}, rep8(8'hA8), 8);
`endif
        chk("ovf8_sat", sat_flag2, 1'b1);
        chk("ovf8_e_out", data_e_out2, 1'b1);
        data_e = 1'b0;
        tick();

        // Asynchronous reset during pass 2 of 4.
        pass_num = 4'd4; data_e = 1'b1;
        tick();
        tick();
        chk("rstmid_busy", busy, 1'b1);
        data_e = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_vec("rstmid_out", data_out, '0, 16);
        chk_vec("rstmid_out8", {{(1024-NC2*8){1'b0}}, data_out2}, '0, 8);
        chk("rstmid_busy0", busy, 1'b0);
        chk("rstmid_e_out", data_e_out, 1'b0);
        chk("rstmid_sat8", sat_flag2, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstrel_e_out1", data_e_out, 1'b0);
        tick();
        chk("rstrel_e_out2", data_e_out, 1'b0);
        chk("rstrel_busy", busy, 1'b0);

        // Normal operation after reset release.
        pass_num = 4'd1; set_all(4'b1111); data_e = 1'b1;
        tick();
        chk_vec("post_rst_sum", data_out, rep16(-16'sd64), 16);
        chk("post_rst_e_out", data_e_out, 1'b1);
        data_e = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/partial_sum_acc.md
PARTIAL_SUM_ACC -- requirements
Module: partial_sum_acc

Interface
REQ-001 The block SHALL have parameter N_MACRO, default 8, number of macro outputs summed per channel.
REQ-002 The block SHALL have parameter N_CH, default 64, number of output channels.
REQ-003 The block SHALL have parameter IN_DW, default 4, macro output width per channel.
REQ-004 The block SHALL have parameter OUT_DW, default 16, accumulator/output width per channel.
REQ-005 The block SHALL have parameter PASS_W, default 4, width of pass count.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 mode  input  1  1 = calculate, 0 = idle/configure.
REQ-009 data_e  input  1  input beat valid, active high.
REQ-010 pass_num  input  PASS_W  beats per accumulation group, sampled on first beat of a group.
REQ-011 acc_clr  input  1  synchronous abort/clear of the current group.
REQ-012 data_in  input  N_MACRO x N_CH x IN_DW  raw macro outputs.
REQ-013 data_out  output  N_CH x OUT_DW signed  accumulated channel sums, registered.
REQ-014 data_e_out  output  1  one-cycle result-valid pulse.
REQ-015 busy  output  1  high while a group is open (state ACC).
REQ-016 sat_flag  output  1  sticky overflow indicator for the last result.

Function
REQ-017 Each input element SHALL be decoded as {in[IN_DW-1], ~in[IN_DW-2:0]} and sign-extended to OUT_DW.
REQ-018 A beat SHALL be accepted only when mode==1 and data_e==1 and acc_clr==0.
REQ-019 Beat sum per channel SHALL be the signed sum of all N_MACRO decoded elements, computed at OUT_DW+clog2(N_MACRO) bits.
REQ-020 State machine SHALL have states IDLE and ACC; reset enters IDLE.
REQ-021 IDLE: accepted beat loads accumulator with beat sum, latches pass_num (0 treated as 1), pass counter=1; goes to ACC, or completes immediately if effective pass_num==1.
REQ-022 ACC: each accepted beat adds beat sum to accumulator and increments pass counter; beats with data_e==0 hold state.
REQ-023 Group SHALL complete on the beat where pass counter reaches latched pass_num; next cycle data_out shows the final sum, data_e_out pulses high for exactly one cycle, state returns to IDLE.
REQ-024 Latency SHALL be one clock from the completing beat to data_e_out.
REQ-025 data_out SHALL hold the last completed result until the next completion; partial sums SHALL never appear on data_out.
REQ-026 A beat accepted in the cycle after completion SHALL start a new group with no bubble (back-to-back groups).
REQ-027 mode==0 or acc_clr==1 while in ACC SHALL abort: accumulator and counter cleared, state to IDLE, no data_e_out, data_out unchanged; acc_clr takes priority over data_e in the same cycle.
REQ-028 pass_num changes while in ACC SHALL be ignored.
REQ-029 sat_flag SHALL update at each completion, high if any channel overflowed OUT_DW during that group.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, accumulators=0, counter=0, data_out all 0, data_e_out=0, busy=0, sat_flag=0.
REQ-031 Reset mid-group SHALL discard the group with no output pulse after release.

Configuration
REQ-032 Macro PSUM_SAT_EN defined: each accumulate step SHALL saturate to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1] and set the channel overflow bit.
REQ-033 PSUM_SAT_EN undefined: accumulation SHALL wrap modulo 2^OUT_DW; sat_flag SHALL still report overflow detection.

Verification
REQ-034 pass_num=1, all data_in=4'b0000 (decoded 7), one beat -> next cycle data_out[k]=56 all channels, data_e_out one-cycle pulse.
REQ-035 pass_num=3, all data_in=4'b1111 (decoded -8), three beats with data_e gaps -> data_out[k]=-192 one cycle after third beat, busy high between.
REQ-036 pass_num=2, one beat then acc_clr=1 -> no data_e_out, data_out unchanged; following 2-beat group correct.
REQ-037 Back-to-back pass_num=1 groups on consecutive cycles with values 7x8 then -8x8 -> data_e_out high two cycles, data_out 56 then -64.
REQ-038 OUT_DW=8, pass_num=3, decoded 7x8 per beat -> with PSUM_SAT_EN data_out=127, sat_flag=1; without, data_out=168 mod 256 as signed (-88), sat_flag=1.
REQ-039 rst_n asserted asynchronously mid-group (pass 2 of 4) -> all outputs 0 immediately, no pulse after release.
